der_box_pipe: RTL and testbench

- Parametrised successor to the fixed 28-bit Dxx box-filter stage in the SURF Hessian detector path.
- Takes eight integral-image corner samples A..H per beat.
- Per beat, a mode bit selects one of two functions:
  - Dxx/Dyy form: (A+E)-(D+H)-3*((B+F)-(C+G))
  - diagonal form: (A+E)+(D+H)-(B+F)-(C+G)
- Full-precision signed 4-stage pipeline with valid/ready backpressure, output saturation to OUT_WIDTH, and a saturation event counter.
- Sits between the integral-image fetch unit and the determinant-of-Hessian multiplier.

---
 rtl/der_box_pipe.sv | 170 +++++++++++++++++
 tb/tb_der_box_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/der_box_pipe.sv
// der_box_pipe: four-stage signed box-filter derivative for the Hessian path.
// Per beat, in_mode selects between the Dxx/Dyy form
//   (A+E)-(D+H)-3*((B+F)-(C+G))
// and the diagonal form
//   (A+E)+(D+H)-(B+F)-(C+G).
// The result is computed at full precision, then clipped to OUT_WIDTH bits.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid & ready are both 1. Once out_valid is high, d_out/d_sat stay stable
// until out_ready accepts them. The pipeline advances as a whole
// (adv = ~out_valid | out_ready), and in_ready is exactly adv.
module der_box_pipe #(
  parameter int DATA_WIDTH = 28,
  parameter int OUT_WIDTH  = 30,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [DATA_WIDTH-1:0]       A,
  input  logic [DATA_WIDTH-1:0]       B,
  input  logic [DATA_WIDTH-1:0]       C,
  input  logic [DATA_WIDTH-1:0]       D,
  input  logic [DATA_WIDTH-1:0]       E,
  input  logic [DATA_WIDTH-1:0]       F,
  input  logic [DATA_WIDTH-1:0]       G,
  input  logic [DATA_WIDTH-1:0]       H,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] d_out,
  output logic                        d_sat,
  output logic [CNT_WIDTH-1:0]        sat_cnt,
  input  logic                        sat_cnt_clr
);

  localparam int S1W = DATA_WIDTH + 1;
  localparam int S2W = DATA_WIDTH + 3;
  localparam int S3W = DATA_WIDTH + 5;

  // Clip bounds, sign-extended to the full-precision width
  localparam logic signed [S3W-1:0] SAT_MAX =
    {{(S3W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [S3W-1:0] SAT_MIN =
    {{(S3W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic w_adv;

  // Stage 1: unsigned pair sums
  logic           r_v1, r_m1;
  logic [S1W-1:0] r_sae, r_sdh, r_sbf, r_scg;

  // Stage 2: signed p/q
  logic                  r_v2, r_m2;
  logic signed [S2W-1:0] r_p2, r_q2;
  logic signed [S2W-1:0] w_sae, w_sdh, w_sbf, w_scg;

  // Stage 3: p delayed, w = q or 3*q
  logic                  r_v3;
  logic signed [S3W-1:0] r_p3, r_w3;
  logic signed [S3W-1:0] w_p2x, w_q2x;

  // Stage 4: final difference and clip
  logic signed [S3W-1:0]       w_r;
  logic                        w_hi, w_lo;
  logic signed [OUT_WIDTH-1:0] w_dout;
  logic                        r_v4;

  assign w_adv     = ~r_v4 | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v4;

  // Zero-extend the unsigned sums into the signed domain
  assign w_sae = $signed({2'b00, r_sae});
  assign w_sdh = $signed({2'b00, r_sdh});
  assign w_sbf = $signed({2'b00, r_sbf});
  assign w_scg = $signed({2'b00, r_scg});

  // Sign-extend stage-2 values to the full-precision width
  assign w_p2x = {{2{r_p2[S2W-1]}}, r_p2};
  assign w_q2x = {{2{r_q2[S2W-1]}}, r_q2};

  // Final difference and clip to the output range
  always_comb begin
    w_r    = r_p3 - r_w3;
    w_hi   = (w_r > SAT_MAX);
    w_lo   = (w_r < SAT_MIN);
    w_dout = w_r[OUT_WIDTH-1:0];
    if (w_hi) begin
      w_dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_lo) begin
      w_dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // Stage 1: register pair sums and the mode tag for the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_m1  <= 1'b0;
      r_sae <= '0;
      r_sdh <= '0;
      r_sbf <= '0;
      r_scg <= '0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_m1  <= in_mode;
      r_sae <= {1'b0, A} + {1'b0, E};
      r_sdh <= {1'b0, D} + {1'b0, H};
      r_sbf <= {1'b0, B} + {1'b0, F};
      r_scg <= {1'b0, C} + {1'b0, G};
    end
  end

  // Stage 2: combine the pair sums according to mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_m2 <= 1'b0;
      r_p2 <= '0;
      r_q2 <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      r_m2 <= r_m1;
      r_p2 <= r_m1 ? (w_sae + w_sdh) : (w_sae - w_sdh);
      r_q2 <= r_m1 ? (w_sbf + w_scg) : (w_sbf - w_scg);
    end
  end

  // Stage 3: weight q by 3 (shift-add) in Dxx/Dyy mode; delay p alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      r_p3 <= '0;
      r_w3 <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      r_p3 <= w_p2x;
      r_w3 <= r_m2 ? w_q2x : ((w_q2x <<< 1) + w_q2x);
    end
  end

  // Stage 4: output registers load only when a valid beat advances into them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v4  <= 1'b0;
      d_out <= '0;
      d_sat <= 1'b0;
    end else if (w_adv) begin
      r_v4 <= r_v3;
      if (r_v3) begin
        d_out <= w_dout;
        d_sat <= w_hi | w_lo;
      end
    end
  end

  // Saturation event counter: clear wins, increment sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (r_v4 && out_ready && d_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_der_box_pipe.sv
// Bench for der_box_pipe: scoreboard of expected {d_sat, d_out} fed at input
// acceptance, monitor popping on every output handshake.
module tb_der_box_pipe;

  localparam int DW = 28;
  localparam int OW = 30;
  localparam int CW = 16;
  localparam logic [DW-1:0] MAXV = {DW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic                 in_valid, in_ready, in_mode;
  logic [DW-1:0]        A, B, C, D, E, F, G, H;
  logic                 out_valid, out_ready;
  logic signed [OW-1:0] d_out;
  logic                 d_sat;
  logic [CW-1:0]        sat_cnt;
  logic                 sat_cnt_clr;

  der_box_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out(d_out), .d_sat(d_sat),
    .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
  );

  // ---------------- scoreboard state ----------------
  logic [OW:0]   exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            n_chk;
  int            n_err;
  logic          ovr_en;
  logic [OW:0]   ovr_val;
  logic          rnd_ready;
  logic          prev_stall;
  logic [OW:0]   prev_val;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW:0] pack_exp(input bit sat, input longint val);
    logic [63:0] v;
    v = val;
    return {sat, v[OW-1:0]};
  endfunction

  // Reference: evaluate the formula on plain integers, then clip
  function automatic logic [OW:0] ref_model(input logic m, input logic [DW-1:0] a, b, c, d,
                                            e, f, g, h);
    longint sae, sdh, sbf, scg, r, maxp, minn;
    sae = longint'(a) + longint'(e);
    sdh = longint'(d) + longint'(h);
    sbf = longint'(b) + longint'(f);
    scg = longint'(c) + longint'(g);
    if (m) r = sae + sdh - sbf - scg;
    else   r = (sae - sdh) - 3 * (sbf - scg);
    maxp = (longint'(1) << (OW - 1)) - 1;
    minn = -(longint'(1) << (OW - 1));
    if (r > maxp) return pack_exp(1'b1, maxp);
    if (r < minn) return pack_exp(1'b1, minn);
    return pack_exp(1'b0, r);
  endfunction

  // Input side: push the expected result for every accepted beat
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (ovr_en) exp_q.push_back(ovr_val);
      else exp_q.push_back(ref_model(in_mode, A, B, C, D, E, F, G, H));
    end
  end

  // Output side: compare on each handshake, track stalls and the counter
  always @(negedge clk) begin
    logic [OW:0] e;
    logic        e_sat;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check(sat_cnt == exp_cnt, "sat_cnt", longint'(sat_cnt), longint'(exp_cnt));
      if (prev_stall) begin
        check(out_valid == 1'b1, "stall_valid", longint'(out_valid), 1);
        check({d_sat, d_out} == prev_val, "stall_hold", longint'({d_sat, d_out}),
              longint'(prev_val));
      end
      e_sat = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_out", longint'(d_out), 0);
        end else begin
          e = exp_q.pop_front();
          e_sat = e[OW];
          check(d_out == e[OW-1:0], "d_out", longint'(d_out),
                longint'($signed(e[OW-1:0])));
          check(d_sat == e[OW], "d_sat", longint'(d_sat), longint'(e[OW]));
        end
      end
      if (sat_cnt_clr) exp_cnt = '0;
      else if (e_sat && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      if (out_valid && !out_ready) begin
        check(in_ready == 1'b0, "in_ready_stall", longint'(in_ready), 0);
        prev_stall = 1'b1;
        prev_val   = {d_sat, d_out};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one beat; returns 2 time units after the accepting edge
  task automatic send(input logic m, input logic [DW-1:0] a, b, c, d, e, f, g, h,
                      input bit use_exp, input logic [OW:0] expv);
    bit acc;
    acc      = 1'b0;
    in_mode  = m;
    A = a; B = b; C = c; D = d; E = e; F = f; G = g; H = h;
    ovr_en   = use_exp;
    ovr_val  = expv;
    in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #2;
      if (acc) break;
    end
    if (!acc) check(1'b0, "accept_timeout", 0, 1);
    in_valid = 1'b0;
    ovr_en   = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check(exp_q.size() == 0, "drain", longint'(exp_q.size()), 0);
  endtask

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return MAXV;
      default: return DW'($urandom());
    endcase
  endfunction

  // Saturating beat with clear asserted on the cycle it is handshaken
  task automatic clr_test();
    send(1'b0, 0, MAXV, 0, 0, 0, MAXV, 0, 0, 1'b1, pack_exp(1'b1, -536870912));
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(posedge clk);
      #2;
    end
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #2;
    sat_cnt_clr = 1'b0;
    check(sat_cnt == '0, "clr_wins", longint'(sat_cnt), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0;
    A = '0; B = '0; C = '0; D = '0; E = '0; F = '0; G = '0; H = '0;
    out_ready = 1'b1; sat_cnt_clr = 1'b0;
    ovr_en = 1'b0; ovr_val = '0; rnd_ready = 1'b0;
    exp_cnt = '0; n_chk = 0; n_err = 0; prev_stall = 1'b0; prev_val = '0;

    #1;
    check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    check(d_out == '0, "rst_d_out", longint'(d_out), 0);
    check(d_sat == 1'b0, "rst_d_sat", longint'(d_sat), 0);
    check(sat_cnt == '0, "rst_sat_cnt", longint'(sat_cnt), 0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);

    // Latency of a single beat
    send(1'b0, 10, 4, 1, 5, 20, 4, 1, 5, 1'b1, pack_exp(1'b0, 2));
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid && lat == 0) lat = k;
    end
    check(lat == 4, "latency", longint'(lat), 4);
    @(posedge clk);
    #2;

    // Alternating modes back to back, then the clip corners
    for (int i = 0; i < 4; i++)
      send(i[0], 10, 4, 1, 5, 20, 4, 1, 5, 1'b1, pack_exp(1'b0, i[0] ? 30 : 2));
    send(1'b0, 0, MAXV, 0, 0, 0, MAXV, 0, 0, 1'b1, pack_exp(1'b1, -536870912));
    send(1'b0, MAXV, 0, 0, 0, MAXV, 0, 0, 0, 1'b1, pack_exp(1'b0, 536870910));
    send(1'b1, MAXV, 0, 0, MAXV, MAXV, 0, 0, MAXV, 1'b1, pack_exp(1'b1, 536870911));
    drain();

    // Eight beats with a 3-cycle downstream stall in the middle
    fork
      begin
        repeat (6) @(posedge clk);
        #2;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++)
      send(i[0], rnd_val(), rnd_val(), rnd_val(), rnd_val(),
           rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0, '0);
    repeat (6) @(posedge clk);
    #2;
    drain();

    // Random traffic with random gaps and backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #2;
      end
      send(1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
           rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b0, '0);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with three beats in flight and the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b0, 0, MAXV, 0, 0, 0, MAXV, 0, 0, 1'b1, pack_exp(1'b1, -536870912));
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "arst_out_valid", longint'(out_valid), 0);
    check(sat_cnt == '0, "arst_sat_cnt", longint'(sat_cnt), 0);
    check(d_out == '0, "arst_d_out", longint'(d_out), 0);
    exp_q.delete();
    exp_cnt = '0;
    out_ready = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check(in_ready == 1'b1, "arst_in_ready", longint'(in_ready), 1);
    repeat (20) @(posedge clk);
    #2;

    // Drive the counter to all-ones, then one more saturation
    for (int i = 0; i < 65536; i++)
      send(1'b0, 0, MAXV, 0, 0, 0, MAXV, 0, 0, 1'b1, pack_exp(1'b1, -536870912));
    drain();
    check(sat_cnt == CNT_MAX, "cnt_stick", longint'(sat_cnt), longint'(CNT_MAX));

    // Clear against a simultaneous saturating handshake, from full and from 1
    clr_test();
    send(1'b0, 0, MAXV, 0, 0, 0, MAXV, 0, 0, 1'b1, pack_exp(1'b1, -536870912));
    drain();
    check(sat_cnt == 1, "cnt_one", longint'(sat_cnt), 1);
    clr_test();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
